ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered operands (PA/PB) and decoded mult/div control, runs radix-2 shift-add multiply or restoring divide over WIDTH cycles, and owns the architectural HI/LO registers.
- Asserts a stall request to the hazard unit while busy, so ID/EX holds dependent instructions.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH
CNT_W, 5, iteration counter width; must be ≥ clog2(WIDTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  ID/EX holds a MULT/MULTU/DIV/DIVU op this cycle
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; others are no-op
rs_val  in  WIDTH  PA operand (multiplicand/dividend, or MTHI/MTLO data)
rt_val  in  WIDTH  PB operand (multiplier/divisor)
mf_req  in  1  ID/EX holds MFHI/MFLO this cycle
flush  in  1  abort in-flight op (branch/exception squash)
busy  out  1  operation in progress
stall_req  out  1  to hazard unit: hold ID/EX
done  out  1  one-cycle pulse: HI/LO just updated by mult/div
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Clocking: clock clk; reset reset, synchronous, active-high.
- Reset (any state, including mid-operation): state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, all internal accumulators 0.
- States: IDLE, RUN, FIXUP.
- IDLE:
  - start with op 0..3 → latch |rs|, |rt| (absolute value for signed ops, raw for unsigned), sign flags; clear accumulator; cnt=0; go to RUN.
  - op 4/5 with start=0 → hi or lo = rs_val at the edge, stay IDLE.
  - start with op 4/5 is treated as MTHI/MTLO.
- RUN: one iteration per edge; cnt increments; after the iteration at cnt==WIDTH-1 go to FIXUP.
  - Multiply: shift-add into a 2*WIDTH product.
  - Divide: restoring subtract; quotient bit shifted into the low half, remainder in the high half.
- FIXUP:
  - Apply sign fixup and write hi/lo.
  - Multiply: hi/lo = upper/lower product; negate the full 2*WIDTH product if signed and operand signs differ.
  - Divide: lo = quotient, hi = remainder. Quotient is negated if signed and operand signs differ; remainder takes the dividend's sign.
  - Go to IDLE; done=1 for the following cycle only.
- Latency: start sampled at edge E0 → RUN edges E1..E32 → hi/lo valid after E33 (WIDTH+1 edges). busy=1 from after E0 through E33 inclusive of that edge's decision.
- stall_req = busy & (start | mf_req | op∈{4,5}). Combinational, no stall while IDLE.
- Requests presented while busy are not accepted; the requester holds them via the stall.
  - start while busy: ignored.
  - MTHI/MTLO while busy: not performed.
- Same-cycle forwarding: none. MFHI on the edge done rises reads the updated hi/lo.
- Divide by zero: full latency; hi = rs_val (original, unsigned view), lo = all ones. Applies to both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Arises naturally from unsigned magnitude 0x80000000 and wrap-around negate; no trap.
- Flush:
  - In RUN or FIXUP: go to IDLE next edge, hi/lo unchanged, done stays 0.
  - In IDLE: flush suppresses start and MTHI/MTLO that cycle.
- Simultaneous flush + reset: reset wins.
- FIXUP edge with done=1 and a new start on the next cycle: accepted normally (back-to-back allowed).

Test Plan:
1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF → after edge 33, hi=0xFFFFFFFE, lo=0x00000001; done pulses one cycle; busy high 33 cycles.
2. MULT rs=0xFFFFFFFD(-3) rt=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV rs=0xFFFFFFF9(-7) rt=2 back-to-back → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIV rs=0x80000000 rt=0xFFFFFFFF → lo=0x80000000, hi=0. DIVU rs=0x1234 rt=0 → hi=0x1234, lo=0xFFFFFFFF.
4. Start MULTU 5*6, assert mf_req and a second start at cycles 3..10 → stall_req=1 exactly those cycles, second start ignored; final hi=0, lo=30. MTLO 0xAA while busy → lo unaffected until IDLE.
5. Start DIVU 100/7; flush at cycle 10 → busy=0 next cycle, hi/lo retain prior values (0/30), done never pulses. Repeat with reset at cycle 10 → hi=lo=0.
6. IDLE: MTHI 0xDEADBEEF then MTLO 0x0BADF00D on consecutive cycles → hi/lo updated at each edge, stall_req=0 throughout.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning HI/LO.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mf_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   orig;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div0;

  logic               op_md;
  logic               op_sgn;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  logic [WIDTH:0]     madd;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     dtmp;
  logic               dge;
  logic [WIDTH-1:0]   dsub;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   q_neg;
  logic [WIDTH-1:0]   r_neg;

  assign op_md  = ~op[2];
  assign op_sgn = ~op[0];
  assign abs_a  = (op_sgn & rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign abs_b  = (op_sgn & rt_val[WIDTH-1]) ? -rt_val : rt_val;

  assign stall_req = busy & (start | mf_req |
                             (op == OP_MTHI) | (op == OP_MTLO));

  // Multiply: conditional add into upper half, then shift right.
  assign madd     = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {madd, acc[WIDTH-1:1]};

  // Divide: shift next dividend bit into remainder, subtract if it fits.
  assign dtmp     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign dge      = dtmp >= {1'b0, opb};
  assign dsub     = dtmp[WIDTH-1:0] - opb;
  assign rem_new  = dge ? dsub : dtmp[WIDTH-1:0];
  assign div_next = {rem_new, acc[WIDTH-2:0], dge};

  assign prod_neg = -acc;
  assign q_neg    = -acc[WIDTH-1:0];
  assign r_neg    = -acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      orig   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!flush) begin
            if (start && op_md) begin
              acc    <= {{WIDTH{1'b0}}, abs_a};
              opb    <= abs_b;
              orig   <= rs_val;
              is_div <= op[1];
              neg_q  <= op_sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              neg_r  <= op_sgn & rs_val[WIDTH-1];
              div0   <= (rt_val == '0);
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end else if (op == OP_MTHI) begin
              hi <= rs_val;
            end else if (op == OP_MTLO) begin
              lo <= rs_val;
            end
          end
        end
        RUN: begin
          if (flush) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
              state <= FIXUP;
          end
        end
        FIXUP: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= neg_q ? prod_neg : acc;
            end else if (div0) begin
              hi <= orig;
              lo <= '1;
            end else begin
              lo <= neg_q ? q_neg : acc[WIDTH-1:0];
              hi <= neg_r ? r_neg : acc[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table, random ops
// against an arithmetic model, and stall/flush/reset sequences.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        flush;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .mf_req(mf_req),
    .flush(flush), .busy(busy), .stall_req(stall_req),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] eh,
                                output logic [31:0] el);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    if (o == 3'd0) begin
      p = 64'(sa * sb);
      {eh, el} = p;
    end else if (o == 3'd1) begin
      p = {32'b0, a} * {32'b0, b};
      {eh, el} = p;
    end else if (b == 32'd0) begin
      eh = a;
      el = '1;
    end else if (o == 3'd2) begin
      q = sa / sb;
      r = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end else begin
      el = a / b;
      eh = a % b;
    end
  endfunction

  // Issue one mult/div op and wait (bounded) for done.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int bcyc,
                       output bit got);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
    bcyc  = 0;
    got   = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) bcyc++;
    end
  endtask

  int          bc;
  bit          got;
  int          dseen;
  logic [31:0] eh;
  logic [31:0] el;
  logic [2:0]  ro;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        exp_st;

  initial begin
    vecs[0] = '{"multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{"mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'd7,
                32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{"div_neg7by2", 3'd2, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{"div_min_by_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF,
                32'h00000000, 32'h80000000};
    vecs[4] = '{"divu_by0", 3'd3, 32'h00001234, 32'd0,
                32'h00001234, 32'hFFFFFFFF};
    vecs[5] = '{"div_by0_neg", 3'd2, 32'hFFFFFFFB, 32'd0,
                32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6] = '{"divu_100by7", 3'd3, 32'd100, 32'd7,
                32'd2, 32'd14};
    vecs[7] = '{"div_7bym2", 3'd2, 32'd7, 32'hFFFFFFFE,
                32'd1, 32'hFFFFFFFD};
    vecs[8] = '{"mult_min_sq", 3'd0, 32'h80000000, 32'h80000000,
                32'h40000000, 32'h00000000};
    vecs[9] = '{"multu_5x6", 3'd1, 32'd5, 32'd6,
                32'd0, 32'd30};

    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd7;
    rs_val = '0;
    rt_val = '0;
    mf_req = 1'b0;
    flush  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);

    // Test 1: latency, busy length, one-cycle done
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, got);
    chk("t1_done", 32'(got), 32'd1);
    chk("t1_busy_cycles", bc, 32'd33);
    chk("t1_hi", hi, 32'hFFFFFFFE);
    chk("t1_lo", lo, 32'h00000001);
    @(negedge clk);
    chk("t1_done_drop", 32'(done), 32'd0);

    // Vector table, issued back to back
    for (int v = 0; v < 10; v++) begin
      do_op(vecs[v].op, vecs[v].a, vecs[v].b, bc, got);
      chk({vecs[v].name, "_done"}, 32'(got), 32'd1);
      chk({vecs[v].name, "_hi"}, hi, vecs[v].ehi);
      chk({vecs[v].name, "_lo"}, lo, vecs[v].elo);
    end

    // Random ops against the arithmetic model
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      model(ro, ra, rb, eh, el);
      do_op(ro, ra, rb, bc, got);
      chk($sformatf("rand%0d_op%0d_done", n, ro), 32'(got), 32'd1);
      chk($sformatf("rand%0d_op%0d_hi", n, ro), hi, eh);
      chk($sformatf("rand%0d_op%0d_lo", n, ro), lo, el);
    end
    @(negedge clk);

    // Test 4: stall window, ignored start, MTLO while busy
    start  = 1'b1;
    op     = 3'd1;
    rs_val = 32'd5;
    rt_val = 32'd6;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 33; k++) begin
      start  = (k >= 3 && k <= 10);
      mf_req = (k >= 3 && k <= 10);
      op     = (k <= 10) ? 3'd1 : 3'd5;
      rs_val = (k <= 10) ? 32'd9 : 32'hAA;
      rt_val = 32'd9;
      exp_st = (k >= 3);
      @(negedge clk);
      chk($sformatf("t4_stall_c%0d", k), 32'(stall_req), 32'(exp_st));
      @(posedge clk);
      #1;
    end
    start  = 1'b0;
    mf_req = 1'b0;
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_hi", hi, 32'd0);
    chk("t4_lo", lo, 32'd30);
    chk("t4_stall_idle", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    op = 3'd7;
    @(negedge clk);
    chk("t4_mtlo_after", lo, 32'hAA);

    // Test 5: flush mid-divide keeps HI/LO
    do_op(3'd1, 32'd5, 32'd6, bc, got);
    start  = 1'b1;
    op     = 3'd3;
    rs_val = 32'd100;
    rt_val = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t5_flush_busy", 32'(busy), 32'd0);
    chk("t5_flush_hi", hi, 32'd0);
    chk("t5_flush_lo", lo, 32'd30);
    dseen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("t5_flush_nodone", dseen, 32'd0);
    chk("t5_flush_lo_late", lo, 32'd30);

    // Same again, aborted by reset
    start  = 1'b1;
    op     = 3'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_hi", hi, 32'd0);
    chk("t5_rst_lo", lo, 32'd0);
    dseen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("t5_rst_nodone", dseen, 32'd0);

    // Test 6: MTHI/MTLO in IDLE, and flush suppression
    @(posedge clk);
    #1;
    op     = 3'd4;
    rs_val = 32'hDEADBEEF;
    @(negedge clk);
    chk("t6_stall_mthi", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    op     = 3'd5;
    rs_val = 32'h0BADF00D;
    @(negedge clk);
    chk("t6_hi", hi, 32'hDEADBEEF);
    chk("t6_stall_mtlo", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    op    = 3'd4;
    rs_val = 32'h11111111;
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("t6_lo", lo, 32'h0BADF00D);
    @(posedge clk);
    #1;
    op    = 3'd7;
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("t6_flush_hi", hi, 32'hDEADBEEF);
    chk("t6_flush_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
